demo_sequencer: RTL and testbench

//  Timeline engine for the demo: owns the demo time counter, advances it on frame ticks, runs a play/pause/done

---
 rtl/demo_pkg.sv | 43 ++++
 rtl/demo_sequencer_if.sv | 42 ++++
 rtl/demo_section_decode.sv | 36 +++
 rtl/demo_sequencer.sv | 126 ++++++++++++
 tb/tb_demo_sequencer.sv | 192 +++++++++++++++++++
 5 files changed

// File: rtl/demo_pkg.sv
// ---------------------------------------------------------------------------
// demo_pkg
// Shared definitions for the demo timeline engine:
//   - seq_state_e  : sequencer FSM states (PAUSE / PLAY / DONE)
//   - CTRL_BITS    : control word width, taken from `DEMO_CONTROL_BITS
//                    (defaults to 16 when the macro is not supplied)
//   - ctrl_word_t  : field layout of the decoded control word
//   - CTRL_*       : bit indices of the control word fields
// Optional build macro used elsewhere in the slice: DEMO_SEQ_JUMP_EN.
// ---------------------------------------------------------------------------
`ifndef DEMO_CONTROL_BITS
`define DEMO_CONTROL_BITS 16
`endif

package demo_pkg;

    localparam int CTRL_BITS = `DEMO_CONTROL_BITS;

    typedef enum logic [1:0] {
        PAUSE = 2'd0,
        PLAY  = 2'd1,
        DONE  = 2'd2
    } seq_state_e;

    // Control word, MSB first. Occupies the low 16 bits of the control bus;
    // any wider bus is zero-padded above.
    typedef struct packed {
        logic       melody_en;    // [15]    melody voice on from section 2
        logic       drum_en;      // [14]    drums on from section 1
        logic [1:0] wave_mode;    // [13:12] synth waveform, changes every 2 sections
        logic [5:0] logo_lines;   // [11:6]  logo raster line count, follows the frame
        logic [2:0] pattern;      // [5:3]   pattern step within the section
        logic [2:0] afl_section;  // [2:0]   section index for effect/logo selection
    } ctrl_word_t;

    localparam int CTRL_AFL_LSB     = 0;
    localparam int CTRL_PATTERN_LSB = 3;
    localparam int CTRL_LOGO_LSB    = 6;
    localparam int CTRL_WAVE_LSB    = 12;
    localparam int CTRL_DRUM_BIT    = 14;
    localparam int CTRL_MELODY_BIT  = 15;

endpackage

// File: rtl/demo_sequencer_if.sv
// ---------------------------------------------------------------------------
// demo_sequencer_if
// Bundles the sequencer's timeline controls and its control-word outputs.
//   master : the sequencer (receives tick/run/loop/restart/jump, drives
//            timer/section/control/section_start/done)
//   slave  : the frame-tick source and control-word consumers
// Signals:
//   tick, run, loop, restart, jump_valid : 1-bit controls
//   jump_section  : TIME_BITS-SECTION_SHIFT bits, jump target section
//   timer         : TIME_BITS bits, current demo time
//   section       : TIME_BITS-SECTION_SHIFT bits, section of control
//   control       : CONTROL_BITS bits, registered control word
//   section_start : 1-cycle pulse on entry to a new section
//   done          : high in DONE
// ---------------------------------------------------------------------------
interface demo_sequencer_if #(
    parameter int TIME_BITS     = 13,
    parameter int SECTION_SHIFT = 10,
    parameter int CONTROL_BITS  = demo_pkg::CTRL_BITS
);
    logic                                tick;
    logic                                run;
    logic                                loop;
    logic                                restart;
    logic                                jump_valid;
    logic [TIME_BITS-SECTION_SHIFT-1:0]  jump_section;
    logic [TIME_BITS-1:0]                timer;
    logic [TIME_BITS-SECTION_SHIFT-1:0]  section;
    logic [CONTROL_BITS-1:0]             control;
    logic                                section_start;
    logic                                done;

    modport master (
        input  tick, run, loop, restart, jump_valid, jump_section,
        output timer, section, control, section_start, done
    );

    modport slave (
        output tick, run, loop, restart, jump_valid, jump_section,
        input  timer, section, control, section_start, done
    );
endinterface

// File: rtl/demo_section_decode.sv
// ---------------------------------------------------------------------------
// demo_section_decode
// Purely combinational map from demo time to control word.
// Ports:
//   timer_i   in  TIME_BITS     demo time
//   control_o out CONTROL_BITS  decoded control word (layout: demo_pkg::ctrl_word_t)
// ---------------------------------------------------------------------------
module demo_section_decode
    import demo_pkg::*;
#(
    parameter int TIME_BITS     = 13,
    parameter int SECTION_SHIFT = 10,
    parameter int CONTROL_BITS  = CTRL_BITS
) (
    input  logic [TIME_BITS-1:0]    timer_i,
    output logic [CONTROL_BITS-1:0] control_o
);

    logic [TIME_BITS-1:0] sec_full;
    ctrl_word_t           word;

    assign sec_full = timer_i >> SECTION_SHIFT;

    always_comb begin
        word.afl_section = 3'(sec_full);
        // Top three bits of the in-section offset: eight pattern steps per section.
        word.pattern     = 3'(timer_i >> (SECTION_SHIFT - 3));
        word.logo_lines  = 6'(timer_i);
        word.wave_mode   = 2'(sec_full >> 1);
        word.drum_en     = (sec_full != '0);
        word.melody_en   = (sec_full >= TIME_BITS'(2));
    end

    assign control_o = CONTROL_BITS'(word);

endmodule

// File: rtl/demo_sequencer.sv
// ---------------------------------------------------------------------------
// demo_sequencer
// Timeline engine: owns the demo timer, advances it on frame ticks under a
// PAUSE/PLAY/DONE state machine and registers the decoded control word.
// Ports:
//   clk    in  clock
//   reset  in  synchronous, active-high reset
//   bus    demo_sequencer_if.master (tick/run/loop/restart/jump in;
//          timer/section/control/section_start/done out)
// Build option: define DEMO_SEQ_JUMP_EN to enable section jumps; otherwise
// jump_valid/jump_section are accepted but ignored.
// All outputs are registers. section, control and section_start lag timer by
// one cycle, so the three always describe the same time step.
// ---------------------------------------------------------------------------
module demo_sequencer
    import demo_pkg::*;
#(
    parameter int TIME_BITS     = 13,
    parameter int SECTION_SHIFT = 10,
    parameter int NUM_SECTIONS  = 8,
    parameter int LOOP_SECTION  = 1,
    parameter int CONTROL_BITS  = CTRL_BITS
) (
    input  logic              clk,
    input  logic              reset,
    demo_sequencer_if.master  bus
);

    localparam int SEC_W = TIME_BITS - SECTION_SHIFT;
    localparam logic [TIME_BITS-1:0] LAST_TIME = TIME_BITS'((NUM_SECTIONS << SECTION_SHIFT) - 1);
    localparam logic [TIME_BITS-1:0] LOOP_TIME = TIME_BITS'(LOOP_SECTION << SECTION_SHIFT);

    seq_state_e              state_q, state_d;
    logic [TIME_BITS-1:0]    timer_q, timer_d;
    logic [CONTROL_BITS-1:0] control_q, control_d;
    logic [SEC_W-1:0]        section_q;
    logic                    section_start_q;
    logic                    done_q;
    logic                    primed_q;      // low until the first post-reset step has been registered
    logic [SEC_W-1:0]        cur_section;
    logic                    jump_take;

    assign cur_section = timer_q[TIME_BITS-1:SECTION_SHIFT];

`ifdef DEMO_SEQ_JUMP_EN
    localparam bit ALL_JUMPS_OK = NUM_SECTIONS >= (1 << SEC_W);
    assign jump_take = bus.jump_valid &&
                       (ALL_JUMPS_OK || ((SEC_W+1)'(bus.jump_section) < (SEC_W+1)'(NUM_SECTIONS)));
`else
    logic unused_jump;
    assign jump_take   = 1'b0;
    assign unused_jump = ^{bus.jump_valid, bus.jump_section};
`endif

    demo_section_decode #(
        .TIME_BITS     (TIME_BITS),
        .SECTION_SHIFT (SECTION_SHIFT),
        .CONTROL_BITS  (CONTROL_BITS)
    ) u_decode (
        .timer_i   (timer_q),
        .control_o (control_d)
    );

    // Priority: restart > jump > run/tick.
    always_comb begin
        // NOTE: every next-state value gets a default first so no path can
        // leave it unassigned and infer a latch.
        state_d = state_q;
        timer_d = timer_q;
        if (bus.restart) begin
            timer_d = '0;
            state_d = bus.run ? PLAY : PAUSE;
        end else if (jump_take) begin
            timer_d = {bus.jump_section, {SECTION_SHIFT{1'b0}}};
            state_d = bus.run ? PLAY : PAUSE;
        end else begin
            case (state_q)
                PAUSE: if (bus.run) state_d = PLAY;
                PLAY: begin
                    // run is looked at before tick: dropping run freezes this very step.
                    if (!bus.run) begin
                        state_d = PAUSE;
                    end else if (bus.tick) begin
                        if (timer_q == LAST_TIME) begin
                            if (bus.loop) timer_d = LOOP_TIME;
                            else          state_d = DONE;
                        end else begin
                            timer_d = timer_q + 1'b1;
                        end
                    end
                end
                default: ;  // DONE: left only through restart or jump
            endcase
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: state uses non-blocking assignments only, and reset is
        // synchronous here, so it is tested inside the clocked block.
        if (reset) begin
            state_q         <= PAUSE;
            timer_q         <= '0;
            control_q       <= '0;
            section_q       <= '0;
            section_start_q <= 1'b0;
            done_q          <= 1'b0;
            primed_q        <= 1'b0;
        end else begin
            state_q         <= state_d;
            timer_q         <= timer_d;
            control_q       <= control_d;
            section_q       <= cur_section;
            // First registered step after reset counts as entering section 0.
            section_start_q <= !primed_q || (cur_section != section_q);
            done_q          <= (state_d == DONE);
            primed_q        <= 1'b1;
        end
    end

    assign bus.timer         = timer_q;
    assign bus.section       = section_q;
    assign bus.control       = control_q;
    assign bus.section_start = section_start_q;
    assign bus.done          = done_q;

endmodule

// File: tb/tb_demo_sequencer.sv
// ---------------------------------------------------------------------------
// tb_demo_sequencer
// Directed bench for demo_sequencer (default parameters). Control words are
// hand-computed from the field layout:
//   t=0    -> 16'h0000   t=5    -> 16'h0140   t=1    -> 16'h0040
//   t=1024 -> 16'h4001   t=3000 -> 16'hDE3A   t=6144 -> 16'hF006
//   t=8191 -> 16'hFFFF
// Honours DEMO_SEQ_JUMP_EN in the jump step.
// ---------------------------------------------------------------------------
module tb_demo_sequencer;

    logic clk = 1'b0;
    logic reset;
    int   n_total = 0;
    int   n_pass  = 0;
    int   ss_count;

    always #5 clk = ~clk;

    demo_sequencer_if ifc ();

    demo_sequencer dut (
        .clk   (clk),
        .reset (reset),
        .bus   (ifc.master)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic run_to(input int target, input int budget, input string tag);
        for (int i = 0; i < budget; i++) begin
            if (int'(ifc.timer) == target) break;
            step();
        end
        check(tag, 32'(ifc.timer), 32'(target));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        reset            = 1'b1;
        ifc.tick         = 1'b0;
        ifc.run          = 1'b0;
        ifc.loop         = 1'b0;
        ifc.restart      = 1'b0;
        ifc.jump_valid   = 1'b0;
        ifc.jump_section = '0;
        step();
        step();
        check("rst_timer",   32'(ifc.timer), 0);
        check("rst_control", 32'(ifc.control), 0);
        check("rst_start",   32'(ifc.section_start), 0);
        check("rst_done",    32'(ifc.done), 0);
        check("rst_section", 32'(ifc.section), 0);

        // 1. leave reset, play five ticks
        reset   = 1'b0;
        ifc.run = 1'b1;
        step();
        check("post_rst_start", 32'(ifc.section_start), 1);
        check("post_rst_ctrl",  32'(ifc.control), 16'h0000);
        ifc.tick = 1'b1;
        ss_count = 0;
        repeat (5) begin
            step();
            ss_count += int'(ifc.section_start);
        end
        ifc.tick = 1'b0;
        step();
        check("t5_timer",    32'(ifc.timer), 5);
        check("t5_section",  32'(ifc.section), 0);
        check("t5_no_start", 32'(ss_count), 0);
        check("t5_control",  32'(ifc.control), 16'h0140);
        check("t5_done",     32'(ifc.done), 0);

        // 2. cross into section 1
        ifc.tick = 1'b1;
        run_to(1022, 2000, "reach_1022");
        step();
        step();
        check("t1024_timer",   32'(ifc.timer), 1024);
        check("t1024_sec_lag", 32'(ifc.section), 0);
        check("t1024_start0",  32'(ifc.section_start), 0);
        step();
        check("sec1_section", 32'(ifc.section), 1);
        check("sec1_start",   32'(ifc.section_start), 1);
        check("sec1_control", 32'(ifc.control), 16'h4001);
        step();
        check("sec1_start_end", 32'(ifc.section_start), 0);
        check("sec1_hold",      32'(ifc.section), 1);

        // 4. loop at the end of the last section
        ifc.loop = 1'b1;
        run_to(8191, 8000, "reach_8191_loop");
        step();
        check("wrap_timer",   32'(ifc.timer), 1024);
        check("wrap_done",    32'(ifc.done), 0);
        check("wrap_ctrl",    32'(ifc.control), 16'hFFFF);
        step();
        check("wrap_section", 32'(ifc.section), 1);
        check("wrap_start",   32'(ifc.section_start), 1);
        check("wrap_ctrl2",   32'(ifc.control), 16'h4001);

        // 3. stop at the end of the last section
        ifc.loop = 1'b0;
        run_to(8191, 8000, "reach_8191_stop");
        step();
        check("done_timer", 32'(ifc.timer), 8191);
        check("done_flag",  32'(ifc.done), 1);
        repeat (3) step();
        check("done_hold_timer", 32'(ifc.timer), 8191);
        check("done_hold_flag",  32'(ifc.done), 1);
        check("done_hold_ctrl",  32'(ifc.control), 16'hFFFF);
        check("done_no_start",   32'(ifc.section_start), 0);

        // 5. restart out of DONE, pause, restart while paused
        ifc.restart = 1'b1;
        step();
        ifc.restart = 1'b0;
        check("restart_timer", 32'(ifc.timer), 0);
        check("restart_done",  32'(ifc.done), 0);
        step();
        check("restart_start", 32'(ifc.section_start), 1);
        check("restart_tick",  32'(ifc.timer), 1);
        run_to(3000, 4000, "reach_3000");
        ifc.run = 1'b0;
        repeat (10) step();
        check("pause_timer",   32'(ifc.timer), 3000);
        check("pause_control", 32'(ifc.control), 16'hDE3A);
        check("pause_section", 32'(ifc.section), 2);
        ifc.restart = 1'b1;
        step();
        ifc.restart = 1'b0;
        check("restart3000_timer", 32'(ifc.timer), 0);
        step();
        check("restart3000_start", 32'(ifc.section_start), 1);
        check("paused_tick_drop",  32'(ifc.timer), 0);
        check("paused_done",       32'(ifc.done), 0);

        // 6. jump with a tick in the same cycle
        ifc.run  = 1'b1;
        ifc.tick = 1'b0;
        step();
        ifc.jump_valid   = 1'b1;
        ifc.jump_section = 3'd6;
        ifc.tick         = 1'b1;
        step();
        ifc.jump_valid = 1'b0;
        ifc.tick       = 1'b0;
`ifdef DEMO_SEQ_JUMP_EN
        check("jump_timer", 32'(ifc.timer), 6144);
        step();
        check("jump_control", 32'(ifc.control), 16'hF006);
        check("jump_section", 32'(ifc.section), 6);
        check("jump_start",   32'(ifc.section_start), 1);
`else
        check("nojump_timer", 32'(ifc.timer), 1);
        step();
        check("nojump_control", 32'(ifc.control), 16'h0040);
        check("nojump_section", 32'(ifc.section), 0);
        check("nojump_start",   32'(ifc.section_start), 0);
`endif

        // restart outranks a simultaneous jump and tick
        ifc.restart      = 1'b1;
        ifc.jump_valid   = 1'b1;
        ifc.jump_section = 3'd3;
        ifc.tick         = 1'b1;
        step();
        ifc.restart    = 1'b0;
        ifc.jump_valid = 1'b0;
        ifc.tick       = 1'b0;
        check("restart_over_jump", 32'(ifc.timer), 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
